// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - framed serial bit-stream receiver with single-entry output buffer
//
// Samples din on every rising clk edge and reassembles frames of the form
// start(1), DATA_W data bits LSB first, [even parity], stop(0) into words.
// Optional feature macro: RX_PARITY_EN (adds a parity bit before the stop bit).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   din         serial stream, idle level 0
//   dout        received word, stable while dout_valid=1
//   dout_valid  word available
//   dout_ready  consumer accepts the word when dout_valid=1
//   frame_err   one-cycle pulse: bad stop bit or bad parity
//   overrun     one-cycle pulse: good frame dropped, buffer still occupied
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;
  logic              stop_good;
  logic              stop_bad;
  logic              load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (din) state_d = S_DATA;
      S_DATA: begin
        if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: state_d = S_STOP;
      // A 1 seen here is a bad stop, never a start bit: always go back to IDLE.
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame verdict is decided on the edge that samples the stop bit.
  assign stop_good = (state_q == S_STOP) && !din && !par_bad;
  assign stop_bad  = (state_q == S_STOP) && !stop_good;
  // Loading is allowed when the buffer is empty or is being drained on the same edge.
  assign load      = stop_good && (!dout_valid || dout_ready);

`ifdef RX_PARITY_EN
  // Parity mismatch is latched and only acted on at the stop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
    end else if (state_q == S_IDLE) begin
      par_bad <= 1'b0;
    end else if (state_q == S_PARITY) begin
      par_bad <= din ^ (^shreg);
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_good && !load;

      if (state_q == S_IDLE) begin
        cnt <= '0;
      end else if (state_q == S_DATA) begin
        shreg[cnt] <= din;
        cnt        <= cnt + 1'b1;
      end

      if (load) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard testbench for serial_frame_rx
module tb_serial_frame_rx;

  localparam int W = 8;
  localparam int EV_ERR = 0;
  localparam int EV_OVR = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         frame_err;
  logic         overrun;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] wq[$];   // words the consumer should receive, in order
  int           eq[$];   // pulse events expected, in order
  bit           m_valid = 1'b0;
  int           rmode = 1;

  serial_frame_rx #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference buffer rule applied at each edge using the inputs present at that edge.
  task automatic tick_m(input logic d, input logic r, input bit is_stop, input bit good,
                        input logic [W-1:0] w);
    bit cons, ld;
    din = d;
    dout_ready = r;
    @(posedge clk);
    cons = m_valid && r;
    ld   = is_stop && good && (!m_valid || r);
    if (is_stop) begin
      if (!good)    eq.push_back(EV_ERR);
      else if (!ld) eq.push_back(EV_OVR);
    end
    if (ld) begin
      wq.push_back(w);
      m_valid = 1'b1;
    end else if (cons) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic tick(input logic d, input logic r);
    tick_m(d, r, 1'b0, 1'b0, '0);
  endtask

  function automatic logic rdy(input bit is_stop);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return logic'($urandom_range(0, 1));
      default: return logic'(is_stop);
    endcase
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit pflip);
    bit good;
    good = !stop;
    tick(1'b1, rdy(1'b0));
    for (int i = 0; i < W; i++) tick(d[i], rdy(1'b0));
`ifdef RX_PARITY_EN
    tick((^d) ^ pflip, rdy(1'b0));
    good = good && !pflip;
`endif
    tick_m(stop, rdy(1'b1), 1'b1, good, d);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a beat or pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (dout_valid && dout_ready) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_word actual=0x%0h required=none", dout);
        end else begin
          check("word", dout, wq.pop_front());
        end
      end
      if (frame_err) begin
        if (eq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_frame_err actual=1 required=0");
        end else check("event_frame_err", EV_ERR, eq.pop_front());
      end
      if (overrun) begin
        if (eq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_overrun actual=1 required=0");
        end else check("event_overrun", EV_OVR, eq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #3;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1'b0, 1'b0);

    // Hold a word, then reset asynchronously mid-frame
    rmode = 0;
    send_frame(8'h5C, 1'b0, 1'b0);
    check("held_5c", dout, 8'h5C);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_valid", dout_valid, 0);
    wq.delete(); eq.delete(); m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Single frame 0xA5, latency and one-cycle valid
    rmode = 1;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_valid", dout_valid, 1);
    check("a5_dout", dout, 8'hA5);
    tick(1'b0, 1'b1);
    check("a5_valid_one_cycle", dout_valid, 0);

    // Back-to-back
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    check("b2b_dout", dout, 8'hC3);
    tick(1'b0, 1'b1);

    // Backpressure / overrun
    rmode = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("bp_overrun", overrun, 1);
    check("bp_dout_kept", dout, 8'h11);
    tick(1'b0, 1'b0);
    check("bp_overrun_one_cycle", overrun, 0);
    tick(1'b0, 1'b1);
    check("bp_consumed", dout_valid, 0);

    // Load and consume on the same edge
    rmode = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    rmode = 3;
    send_frame(8'h22, 1'b0, 1'b0);
    check("lc_dout", dout, 8'h22);
    check("lc_valid", dout_valid, 1);
    check("lc_no_overrun", overrun, 0);
    tick(1'b0, 1'b1);

    // Bad stop bit, then a good frame right behind it
    rmode = 1;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("badstop_err", frame_err, 1);
    check("badstop_valid", dout_valid, 0);
    send_frame(8'h01, 1'b0, 1'b0);
    check("after_bad_dout", dout, 8'h01);
    check("after_bad_valid", dout_valid, 1);
    tick(1'b0, 1'b1);

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_err", frame_err, 1);
    check("par_no_valid", dout_valid, 0);
    send_frame(8'h07, 1'b0, 1'b0);
    check("par_ok_dout", dout, 8'h07);
    tick(1'b0, 1'b1);
`endif

    // Randomized traffic
    for (int f = 0; f < 80; f++) begin
      logic [W-1:0] d;
      int gap;
      d = W'($urandom);
      rmode = $urandom_range(0, 2);
      send_frame(d, logic'($urandom_range(0, 99) < 15), $urandom_range(0, 99) < 10);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick(1'b0, rdy(1'b0));
    end

    // Drain
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    check("drain_words", wq.size(), 0);
    check("drain_events", eq.size(), 0);
    check("drain_valid", dout_valid, m_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
